entrada_decimal: RTL

- Decimal keypad entry block; the reverse direction of the team's binary-to-7-segment display driver.
- Accepts up to four decimal digit strobes, most significant first, and holds them as BCD for the display path.
- On confirmation, converts the BCD digits sequentially into a 16-bit binary value (0–9999).
- Sits between the debounced keypad front-end and any consumer of a 16-bit operand.

---
 rtl/entrada_decimal_pkg.sv | 19 +
 rtl/entrada_decimal_mul10_soma.sv | 19 +
 rtl/entrada_decimal.sv | 126 ++++++++++++
 3 files changed

// File: rtl/entrada_decimal_pkg.sv
// entrada_decimal_pkg: shared types and constants for the decimal keypad entry block.
//   estado_t     : controller state (ENTRADA collects digits, CONVERTE runs BCD->binary)
//   NUM_DIGITOS  : BCD digit capacity
//   MAX_VALOR    : largest value a full entry can produce
//   DIGITO_MAX   : largest legal digit code
//   ACC_W        : accumulator width (9999 fits in 14 bits)
package entrada_decimal_pkg;

    typedef enum logic [0:0] {
        ENTRADA  = 1'b0,
        CONVERTE = 1'b1
    } estado_t;

    localparam int unsigned NUM_DIGITOS = 4;
    localparam logic [15:0] MAX_VALOR   = 16'd9999;
    localparam logic [3:0]  DIGITO_MAX  = 4'd9;
    localparam int unsigned ACC_W       = 14;

endpackage

// File: rtl/entrada_decimal_mul10_soma.sv
// mul10_soma: combinational conversion step, resultado = acc * 10 + digito.
//   acc       in  14  running accumulator
//   digito    in  4   BCD digit to append
//   resultado out 14  new accumulator value
// The product is built from shifts ((acc << 3) + (acc << 1)) so no multiplier is inferred.
// Callers guarantee the result never exceeds 9999, so the 14-bit result cannot overflow.
module mul10_soma
    import entrada_decimal_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digito,
    output logic [ACC_W-1:0] resultado
);

    always_comb begin
        resultado = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digito};
    end

endmodule

// File: rtl/entrada_decimal.sv
// entrada_decimal: decimal keypad entry. Collects up to four BCD digits (MSD first) and,
// on confirmation, converts them to a 16-bit binary value in four sequential steps.
//   clk, rst (async, active-high)
//   digito/digito_valido : digit code and its one-cycle strobe
//   apagar               : remove last digit (only when ENTRADA_DECIMAL_APAGAR_EN is defined)
//   confirmar            : start conversion
//   limpar               : discard entry or abort conversion
//   bcd, contagem        : current entry (right-aligned nibbles) and digit count
//   ocupado              : conversion in progress
//   valor, valor_valido  : last converted value and its one-cycle update pulse
//   erro                 : one-cycle pulse on a rejected strobe
// Optional feature macro: ENTRADA_DECIMAL_APAGAR_EN (enables the apagar strobe).
module entrada_decimal
    import entrada_decimal_pkg::*;
#(
    parameter int unsigned NUM_DIGITOS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digito,
    input  logic        digito_valido,
    input  logic        apagar,
    input  logic        confirmar,
    input  logic        limpar,
    output logic [15:0] bcd,
    output logic [2:0]  contagem,
    output logic        ocupado,
    output logic [15:0] valor,
    output logic        valor_valido,
    output logic        erro
);

    estado_t          estado;
    logic [ACC_W-1:0] acc;
    logic [1:0]       indice;
    logic [3:0]       digito_atual;
    logic [ACC_W-1:0] acc_proximo;

    // Digit consumed by the current step, most significant nibble first.
    always_comb begin
        digito_atual = bcd[{indice, 2'b00} +: 4];
    end

    mul10_soma u_mul10_soma (
        .acc      (acc),
        .digito   (digito_atual),
        .resultado(acc_proximo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado       <= ENTRADA;
            acc          <= '0;
            indice       <= '0;
            bcd          <= '0;
            contagem     <= '0;
            ocupado      <= 1'b0;
            valor        <= '0;
            valor_valido <= 1'b0;
            erro         <= 1'b0;
        end else begin
            valor_valido <= 1'b0;
            erro         <= 1'b0;
            unique case (estado)
                ENTRADA: begin
                    if (limpar) begin
                        bcd      <= '0;
                        contagem <= '0;
                    end else if (confirmar) begin
                        if (contagem == 3'd0) begin
                            erro <= 1'b1;
                        end else begin
                            estado  <= CONVERTE;
                            ocupado <= 1'b1;
                            acc     <= '0;
                            indice  <= 2'd3;
                        end
                    end else if (apagar) begin
                        // Without the feature, apagar still outranks digito_valido but does nothing.
`ifdef ENTRADA_DECIMAL_APAGAR_EN
                        if (contagem == 3'd0) begin
                            erro <= 1'b1;
                        end else begin
                            bcd      <= {4'd0, bcd[15:4]};
                            contagem <= contagem - 3'd1;
                        end
`endif
                    end else if (digito_valido) begin
                        if ((digito > DIGITO_MAX) || (contagem == 3'(NUM_DIGITOS))) begin
                            erro <= 1'b1;
                        end else begin
                            bcd      <= {bcd[11:0], digito};
                            contagem <= contagem + 3'd1;
                        end
                    end
                end
                CONVERTE: begin
                    if (limpar) begin
                        // Abort: entry is discarded, previous valor is kept.
                        estado   <= ENTRADA;
                        ocupado  <= 1'b0;
                        bcd      <= '0;
                        contagem <= '0;
                    end else begin
                        acc <= acc_proximo;
                        if (indice == 2'd0) begin
                            estado       <= ENTRADA;
                            ocupado      <= 1'b0;
                            valor        <= {{(16-ACC_W){1'b0}}, acc_proximo};
                            valor_valido <= 1'b1;
                            bcd          <= '0;
                            contagem     <= '0;
                        end else begin
                            indice <= indice - 2'd1;
                        end
                    end
                end
                default: begin
                    estado  <= ENTRADA;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule
